// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HELD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic        valid;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc_4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that parks a ROM response arriving while decode is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t d,
  output fetch_entry_t q
);

  always_ff @(posedge clk) begin
    if (!reset || clear) q <= EMPTY_ENTRY;
    else if (load)       q <= d;
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC, synchronous ROM addressing, stall skid and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN flags misaligned/out-of-range redirects as a sticky fault.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          AW           = $clog2(MEMORY_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] imem_word_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   fetch_pc,
  output logic [31:0]   if_id_instruction,
  output logic [31:0]   if_id_pc_4,
  output logic          if_id_valid,
  output logic          fetch_fault
);

  logic [31:0]  pc_q, inflight_pc4;
  logic         inflight_q, fire, fault_q;
  logic         skid_load, skid_clear;
  fetch_state_t state_q;
  fetch_entry_t if_id_q, skid_q, rsp;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_set;
  assign fault_set = redirect_valid &&
                     ((redirect_pc[1:0] != 2'b00) ||
                      (((redirect_pc - RESET_PC) >> 2) >= 32'(MEMORY_DEPTH)));

  always_ff @(posedge clk) begin
    if (!reset)         fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
`else
  assign fault_q = 1'b0;
`endif

  // Truncation gives the modulo-depth wrap of the word index.
  assign imem_word_addr = AW'((pc_q - RESET_PC) >> 2);
  assign fire           = !stall && !redirect_valid && !fault_q;
  assign rsp            = '{instr: imem_rdata, pc_4: inflight_pc4, valid: inflight_q};

  // Park the response only when it actually arrives during a stall in RUN.
  assign skid_load  = !redirect_valid && (state_q == RUN) && stall && inflight_q;
  assign skid_clear = redirect_valid || ((state_q == HELD) && !stall);

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     ('{instr: imem_rdata, pc_4: inflight_pc4, valid: 1'b1}),
    .q     (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflight_pc4 <= 32'h0;
      state_q      <= RUN;
      if_id_q      <= EMPTY_ENTRY;
    end else begin
      inflight_q <= fire;
      if (fire) begin
        pc_q         <= pc_q + 32'd4;
        inflight_pc4 <= pc_q + 32'd4;
      end
      if (redirect_valid) begin
        pc_q    <= redirect_pc & ~32'h3;
        state_q <= RUN;
        if_id_q <= EMPTY_ENTRY;
      end else if (state_q == HELD) begin
        if (!stall) begin
          if_id_q <= skid_q;
          state_q <= RUN;
        end
      end else if (!stall) begin
        if_id_q <= rsp;
      end else if (inflight_q) begin
        state_q <= HELD;
      end
    end
  end

  assign fetch_pc          = pc_q;
  assign if_id_instruction = if_id_q.instr;
  assign if_id_pc_4        = if_id_q.pc_4;
  assign if_id_valid       = if_id_q.valid;
  assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a randomized run against a queue-based fetch model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 512;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_rdata, fetch_pc, if_id_instruction, if_id_pc_4;
  logic [8:0]  imem_word_addr;
  logic        if_id_valid, fetch_fault;

  logic [31:0] rom [0:DEPTH-1];
  int checks = 0, errors = 0;

  // Reference model: addresses already requested but not yet delivered, plus the IF/ID contents.
  logic [31:0] q_addr[$];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_exact, m_fault;

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= rom[imem_word_addr];

  instruction_fetch_stage #(.MEMORY_DEPTH(DEPTH), .RESET_PC(RST_PC), .AW(9)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_word_addr(imem_word_addr), .imem_rdata(imem_rdata),
    .fetch_pc(fetch_pc), .if_id_instruction(if_id_instruction), .if_id_pc_4(if_id_pc_4),
    .if_id_valid(if_id_valid), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] off;
    off = (a - RST_PC) >> 2;
    return rom[off[8:0]];
  endfunction

  function automatic void model_step(input logic st, input logic rv, input logic [31:0] rpc,
                                     input logic rs);
    logic [31:0] a;
    if (!rs) begin
      m_pc = RST_PC; q_addr.delete(); m_fault = 1'b0;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_exact = 1'b1;
    end else if (rv) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00 || ((rpc - RST_PC) >> 2) >= DEPTH) m_fault = 1'b1;
`endif
      m_pc = {rpc[31:2], 2'b00}; q_addr.delete();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_exact = 1'b1;
    end else if (!st) begin
      if (q_addr.size() > 0) begin
        a = q_addr.pop_front();
        m_instr = rom_at(a); m_pc4 = a + 32'd4; m_valid = 1'b1; m_exact = 1'b1;
      end else begin
        m_valid = 1'b0; m_exact = 1'b0;
      end
      if (!m_fault) begin
        q_addr.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  // Drive one cycle's inputs at the falling edge; outputs are sampled at the next falling edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc, input logic rs);
    stall = st; redirect_valid = rv; redirect_pc = rpc; reset = rs;
    @(posedge clk);
    model_step(st, rv, rpc, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h0040_0100, 0);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_4 !== 32'h0 ||
        fetch_pc !== RST_PC || imem_word_addr !== 9'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b i=%h p4=%h pc=%h wa=%0d f=%b exp v=0 i=0 p4=0 pc=%h wa=0 f=0",
               if_id_valid, if_id_instruction, if_id_pc_4, fetch_pc, imem_word_addr, fetch_fault, RST_PC);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_i [0:3];
    exp_i[0] = 32'h2008_0001; exp_i[1] = 32'h2009_0002; exp_i[2] = 32'h0109_5020; exp_i[3] = 32'h0;
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b0 || imem_word_addr !== 9'd1) begin
      errors++;
      $display("FAIL free_run_first_bubble got v=%b wa=%0d exp v=0 wa=1", if_id_valid, imem_word_addr);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instruction !== exp_i[k] ||
          if_id_pc_4 !== RST_PC + 32'(4 * (k + 1))) begin
        errors++;
        $display("FAIL free_run_%0d got v=%b i=%h p4=%h exp v=1 i=%h p4=%h", k, if_id_valid,
                 if_id_instruction, if_id_pc_4, exp_i[k], RST_PC + 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_stall();
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 1);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instruction !== 32'h2009_0002 ||
          if_id_pc_4 !== 32'h0040_0008 || fetch_pc !== 32'h0040_000C) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b i=%h p4=%h pc=%h exp v=1 i=20090002 p4=00400008 pc=0040000c",
                 k, if_id_valid, if_id_instruction, if_id_pc_4, fetch_pc);
      end
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== 32'h0109_5020 || if_id_pc_4 !== 32'h0040_000C) begin
      errors++;
      $display("FAIL stall_release got v=%b i=%h p4=%h exp v=1 i=01095020 p4=0040000c",
               if_id_valid, if_id_instruction, if_id_pc_4);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== 32'h0 || if_id_pc_4 !== 32'h0040_0010) begin
      errors++;
      $display("FAIL stall_after_release got v=%b i=%h p4=%h exp v=1 i=0 p4=00400010",
               if_id_valid, if_id_instruction, if_id_pc_4);
    end
  endtask

  task automatic test_redirect_held();
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h0040_0020, 1);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || fetch_pc !== 32'h0040_0020) begin
      errors++;
      $display("FAIL redirect_flush got v=%b i=%h pc=%h exp v=0 i=0 pc=00400020",
               if_id_valid, if_id_instruction, fetch_pc);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_bubble got v=%b exp v=0", if_id_valid);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== rom[8] || if_id_pc_4 !== 32'h0040_0024) begin
      errors++;
      $display("FAIL redirect_target got v=%b i=%h p4=%h exp v=1 i=%h p4=00400024",
               if_id_valid, if_id_instruction, if_id_pc_4, rom[8]);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) cycle(0, 0, 0, 1);
    cycle(1, 1, 32'h0040_0010, 1);
    cycle(0, 1, 32'h0040_0040, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b0 || fetch_pc !== 32'h0040_0044) begin
      errors++;
      $display("FAIL b2b_bubble got v=%b pc=%h exp v=0 pc=00400044", if_id_valid, fetch_pc);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instruction !== rom[16 + k] ||
          if_id_pc_4 !== 32'h0040_0044 + 32'(4 * k)) begin
        errors++;
        $display("FAIL b2b_target_%0d got v=%b i=%h p4=%h exp v=1 i=%h p4=%h", k, if_id_valid,
                 if_id_instruction, if_id_pc_4, rom[16 + k], 32'h0040_0044 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_reset_mid_held();
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_4 !== 32'h0 || fetch_pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_mid_held got v=%b i=%h p4=%h pc=%h exp v=0 i=0 p4=0 pc=%h",
               if_id_valid, if_id_instruction, if_id_pc_4, fetch_pc, RST_PC);
    end
    repeat (2) cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== 32'h2008_0001 || if_id_pc_4 !== 32'h0040_0004) begin
      errors++;
      $display("FAIL reset_restart got v=%b i=%h p4=%h exp v=1 i=20080001 p4=00400004",
               if_id_valid, if_id_instruction, if_id_pc_4);
    end
  endtask

  task automatic test_align();
    cycle(0, 1, 32'h0040_0022, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      cycle(k == 1, 0, 0, 1);
      checks++;
      if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL align_fault_%0d got f=%b v=%b exp f=1 v=0", k, fetch_fault, if_id_valid);
      end
    end
`else
    checks++;
    if (fetch_pc !== 32'h0040_0020 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL align_clear got pc=%h f=%b exp pc=00400020 f=0", fetch_pc, fetch_fault);
    end
    repeat (2) cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== rom[8] || if_id_pc_4 !== 32'h0040_0024) begin
      errors++;
      $display("FAIL align_fetch got v=%b i=%h p4=%h exp v=1 i=%h p4=00400024",
               if_id_valid, if_id_instruction, if_id_pc_4, rom[8]);
    end
    // Past the end of the ROM: word index wraps back to 2.
    cycle(0, 1, RST_PC + 32'(DEPTH * 4 + 8), 1);
    repeat (2) cycle(0, 0, 0, 1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instruction !== rom[2] || if_id_pc_4 !== RST_PC + 32'(DEPTH * 4 + 12)) begin
      errors++;
      $display("FAIL wrap_fetch got v=%b i=%h p4=%h exp v=1 i=%h p4=%h", if_id_valid,
               if_id_instruction, if_id_pc_4, rom[2], RST_PC + 32'(DEPTH * 4 + 12));
    end
`endif
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic st, rv, rs;
    logic [31:0] rpc, woff;
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 10);
      rs  = ($urandom_range(0, 99) >= 1);
      rpc = RST_PC + 32'($urandom_range(0, 600) << 2);
      if ($urandom_range(0, 15) == 0) rpc = rpc + 32'($urandom_range(1, 3));
      cycle(st, rv, rpc, rs);
      woff = (m_pc - RST_PC) >> 2;
      checks++;
      if (if_id_valid !== m_valid || fetch_pc !== m_pc || fetch_fault !== m_fault ||
          imem_word_addr !== woff[8:0] ||
          ((m_valid || m_exact) && (if_id_instruction !== m_instr || if_id_pc_4 !== m_pc4))) begin
        errors++;
        $display("FAIL random_%0d got v=%b pc=%h wa=%0d i=%h p4=%h f=%b exp v=%b pc=%h wa=%0d i=%h p4=%h f=%b",
                 c, if_id_valid, fetch_pc, imem_word_addr, if_id_instruction, if_id_pc_4, fetch_fault,
                 m_valid, m_pc, woff[8:0], m_instr, m_pc4, m_fault);
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002; rom[2] = 32'h0109_5020; rom[3] = 32'h0;
    rom[4] = 32'h2108_0004;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_held();
    test_back_to_back();
    test_reset_mid_held();
    test_align();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
